// File: rtl/avalon_copier_pkg.sv
// Shared types and default sizing for the Avalon-MM block copier.
package avalon_copier_pkg;

    localparam int unsigned DEF_ADDR_W       = 13;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_DEPTH        = 5120;
    localparam int unsigned DEF_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRd,
        StRdWait,
        StWr,
        StDone
    } copier_state_e;

endpackage

// File: rtl/avalon_rd_latency_tracker.sv
// Delays a read-acceptance strobe by READ_LATENCY cycles so the copier knows
// exactly which cycle carries valid readdata.
module avalon_rd_latency_tracker
    import avalon_copier_pkg::*;
#(
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept,
    output logic capture
);

    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;

    // Shift the acceptance strobe one stage per cycle.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = accept;
        for (int k = 1; k < int'(READ_LATENCY); k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    // Pipeline storage; cleared so an aborted read never fires a late capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign capture = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/avalon_mm_block_copier.sv
// Avalon-MM master that copies a block of words from src to dst, one word at
// a time (read, wait for data, write), with bounds checking against DEPTH.
module avalon_mm_block_copier
    import avalon_copier_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                read,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest
);

    copier_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W:0]     idx_next;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                cs_q, cs_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [31:0]         src_end, dst_end;
    logic                out_of_range;
    logic                rd_accept;
    logic                rd_capture;

    assign rd_accept = read_q && !waitrequest;

    avalon_rd_latency_tracker #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_tracker (
        .clk    (clk),
        .reset_n(reset_n),
        .accept (rd_accept),
        .capture(rd_capture)
    );

    // Bounds check in 32 bits so src+count cannot wrap.
    always_comb begin
        src_end      = 32'(src_q) + 32'(count_q);
        dst_end      = 32'(dst_q) + 32'(count_q);
        out_of_range = (src_end > DEPTH) || (dst_end > DEPTH);
        idx_next     = idx_q + (ADDR_W + 1)'(1);
    end

    // Next-state and next-output decode; every bus output is registered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = word_count;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (out_of_range) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    read_d  = 1'b1;
                    addr_d  = src_q;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (rd_capture) begin
                    wdata_d = readdata;
                    write_d = 1'b1;
                    be_d    = '1;
                    addr_d  = dst_q + idx_q[ADDR_W-1:0];
                    state_d = StWr;
                end
            end
            StWr: begin
                if (!waitrequest) begin
                    write_d = 1'b0;
                    be_d    = '0;
                    idx_d   = idx_next;
                    if (idx_next < count_q) begin
                        read_d  = 1'b1;
                        addr_d  = src_q + idx_next[ADDR_W-1:0];
                        state_d = StRd;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cs_d = read_d || write_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cs_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            read_q  <= read_d;
            write_q <= write_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign read       = read_q;
    assign write      = write_q;
    assign chipselect = cs_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_mm_block_copier.sv
// Directed bench for avalon_mm_block_copier with a latency-1 memory model.
module tb_avalon_mm_block_copier;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] src_addr = '0;
    logic [12:0] dst_addr = '0;
    logic [13:0] word_count = '0;
    logic        busy, done, error;
    logic [12:0] address;
    logic        chipselect, read, write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;
    logic        waitrequest;

    int checks = 0;
    int failures = 0;

    avalon_mm_block_copier dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .readdata   (readdata),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    // Memory model: fixed read latency of 1, optional 3-cycle stall per command.
    logic [31:0] mem [0:5119];
    logic        stall_en = 1'b0;
    int          stall_cnt = 0;

    always_comb waitrequest = stall_en && (read || write) && (stall_cnt < 3);

    always @(posedge clk) begin
        if (read || write) begin
            if (waitrequest) stall_cnt <= stall_cnt + 1;
            else             stall_cnt <= 0;
        end
        if (read && !waitrequest)  readdata <= mem[address];
        if (write && !waitrequest) mem[address] <= writedata;
    end

    // Bus monitor sampled on the falling edge.
    int          busy_cyc, done_cnt, err_cnt, rw_cyc, proto_err, unstable;
    logic        prev_stall = 1'b0;
    logic        prev_rd, prev_wr;
    logic [12:0] prev_addr;
    logic [31:0] prev_wd;

    always @(negedge clk) begin
        if (busy)  busy_cyc++;
        if (done)  done_cnt++;
        if (error) err_cnt++;
        if (read || write) rw_cyc++;
        if ((read && write) || (chipselect != (read || write))) proto_err++;
        if (write && byteenable != 4'hF) proto_err++;
        if (prev_stall && (read != prev_rd || write != prev_wr || address != prev_addr ||
                           (write && writedata != prev_wd))) unstable++;
        prev_stall = (read || write) && waitrequest;
        prev_rd    = read;
        prev_wr    = write;
        prev_addr  = address;
        prev_wd    = writedata;
    end

    task automatic clear_mon();
        busy_cyc = 0; done_cnt = 0; err_cnt = 0; rw_cyc = 0; proto_err = 0; unstable = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_start(input logic [12:0] s, input logic [12:0] d, input logic [13:0] c);
        @(negedge clk);
        src_addr = s; dst_addr = d; word_count = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clear_mon();
    endtask

    // n = falling edges from the CHECK cycle (1) up to and including done.
    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (done) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, error, read, write, chipselect} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {busy, done, error, read, write, chipselect});
        end
        checks++;
        if (address !== 13'd0) begin
            failures++; $display("FAIL reset_address got=%0d want=0", address);
        end
        checks++;
        if (writedata !== 32'd0) begin
            failures++; $display("FAIL reset_writedata got=%h want=0", writedata);
        end
        checks++;
        if (byteenable !== 4'd0) begin
            failures++; $display("FAIL reset_byteenable got=%h want=0", byteenable);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n; bit ok;
        for (int i = 0; i < 4; i++) begin mem[i] = 32'hA5A5_0000 + i; mem[100+i] = '0; end
        do_start(13'd0, 13'd100, 14'd4);
        wait_done(100, n, ok);
        checks++;
        if (!ok || n != 14) begin
            failures++; $display("FAIL basic_done_latency got=%0d ok=%0b want=14", n, ok);
        end
        checks++;
        if (busy_cyc != 12) begin
            failures++; $display("FAIL basic_busy_cycles got=%0d want=12", busy_cyc);
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL basic_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
        end
        checks++;
        if (rw_cyc != 8 || proto_err != 0) begin
            failures++;
            $display("FAIL basic_bus got rw=%0d proto=%0d want 8/0", rw_cyc, proto_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[100+i] !== 32'hA5A5_0000 + i) begin
                failures++;
                $display("FAIL basic_data[%0d] got=%h want=%h", i, mem[100+i], 32'hA5A5_0000 + i);
            end
        end
    endtask

    task automatic test_zero_count();
        int n; bit ok;
        do_start(13'd7, 13'd9, 14'd0);
        wait_done(20, n, ok);
        checks++;
        if (!ok || n != 2) begin
            failures++; $display("FAIL zero_done_latency got=%0d ok=%0b want=2", n, ok);
        end
        checks++;
        if (rw_cyc != 0 || err_cnt != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_bus got rw=%0d err=%0d done=%0d want 0/0/1",
                     rw_cyc, err_cnt, done_cnt);
        end
    endtask

    task automatic test_range_error();
        int n; bit ok;
        do_start(13'd5118, 13'd0, 14'd3);
        repeat (6) @(negedge clk);
        checks++;
        if (err_cnt != 1 || rw_cyc != 0 || done_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL range_src got err=%0d rw=%0d done=%0d busy=%0b want 1/0/0/0",
                     err_cnt, rw_cyc, done_cnt, busy);
        end
        do_start(13'd0, 13'd5120, 14'd1);
        repeat (6) @(negedge clk);
        checks++;
        if (err_cnt != 1 || rw_cyc != 0) begin
            failures++;
            $display("FAIL range_dst got err=%0d rw=%0d want 1/0", err_cnt, rw_cyc);
        end
        // Exactly reaching DEPTH is legal.
        for (int i = 0; i < 3; i++) begin mem[5117+i] = 32'hC0DE_0000 + i; mem[i] = '0; end
        do_start(13'd5117, 13'd0, 14'd3);
        wait_done(100, n, ok);
        checks++;
        if (!ok || err_cnt != 0) begin
            failures++; $display("FAIL range_edge got ok=%0b err=%0d want 1/0", ok, err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[i] !== 32'hC0DE_0000 + i) begin
                failures++;
                $display("FAIL range_edge_data[%0d] got=%h want=%h", i, mem[i], 32'hC0DE_0000 + i);
            end
        end
    endtask

    task automatic test_stall();
        int n; bit ok;
        mem[10] = 32'h1111_2222; mem[11] = 32'h3333_4444; mem[200] = '0; mem[201] = '0;
        stall_en = 1'b1;
        do_start(13'd10, 13'd200, 14'd2);
        wait_done(200, n, ok);
        stall_en = 1'b0;
        checks++;
        if (!ok || busy_cyc != 18) begin
            failures++; $display("FAIL stall_busy got=%0d ok=%0b want=18", busy_cyc, ok);
        end
        checks++;
        if (unstable != 0 || proto_err != 0) begin
            failures++;
            $display("FAIL stall_stable got unstable=%0d proto=%0d want 0/0", unstable, proto_err);
        end
        checks++;
        if (mem[200] !== 32'h1111_2222 || mem[201] !== 32'h3333_4444) begin
            failures++;
            $display("FAIL stall_data got=%h,%h want=11112222,33334444", mem[200], mem[201]);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit found; int d; int rw;
        for (int i = 0; i < 5; i++) begin mem[20+i] = 32'hBEEF_0000 + i; mem[300+i] = '0; end
        do_start(13'd20, 13'd300, 14'd5);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (write && address == 13'd302) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rstmid_reach got=0 want=1");
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({busy, done, error, read, write, chipselect} !== 6'b0 || address !== 13'd0 ||
            writedata !== 32'd0 || byteenable !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got ctrl=%b addr=%0d wd=%h be=%h want all zero",
                     {busy, done, error, read, write, chipselect}, address, writedata, byteenable);
        end
        d = 0; rw = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) d++;
            if (read || write) rw++;
        end
        checks++;
        if (d != 0 || rw != 0) begin
            failures++; $display("FAIL rstmid_quiet got done=%0d rw=%0d want 0/0", d, rw);
        end
        for (int i = 0; i < 5; i++) mem[300+i] = '0;
        do_start(13'd20, 13'd300, 14'd5);
        wait_done(100, n, ok);
        checks++;
        if (!ok || done_cnt != 1 || busy_cyc != 15) begin
            failures++;
            $display("FAIL rstmid_restart got ok=%0b done=%0d busy=%0d want 1/1/15",
                     ok, done_cnt, busy_cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem[300+i] !== 32'hBEEF_0000 + i) begin
                failures++;
                $display("FAIL rstmid_data[%0d] got=%h want=%h", i, mem[300+i], 32'hBEEF_0000 + i);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n; bit ok;
        for (int i = 0; i < 3; i++) begin mem[40+i] = 32'h4040_0000 + i; mem[400+i] = '0; end
        mem[0] = 32'h1234_5678;
        do_start(13'd40, 13'd400, 14'd3);
        repeat (3) @(negedge clk);
        src_addr = 13'd0; dst_addr = 13'd0; word_count = 14'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, n, ok);
        checks++;
        if (!ok || done_cnt != 1 || busy_cyc != 9) begin
            failures++;
            $display("FAIL ignore_pulses got ok=%0b done=%0d busy=%0d want 1/1/9",
                     ok, done_cnt, busy_cyc);
        end
        checks++;
        if (mem[0] !== 32'h1234_5678) begin
            failures++; $display("FAIL ignore_untouched got=%h want=12345678", mem[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[400+i] !== 32'h4040_0000 + i) begin
                failures++;
                $display("FAIL ignore_data[%0d] got=%h want=%h", i, mem[400+i], 32'h4040_0000 + i);
            end
        end
    endtask

    task automatic test_overlap();
        int n; bit ok;
        mem[50] = 32'hAAAA_0001; mem[51] = 32'hBBBB_0002;
        mem[52] = 32'hCCCC_0003; mem[53] = 32'hDDDD_0004;
        do_start(13'd50, 13'd51, 14'd3);
        wait_done(100, n, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL overlap_done got=0 want=1");
        end
        // Ascending copy onto an overlapping window smears the first word forward.
        for (int i = 51; i <= 53; i++) begin
            checks++;
            if (mem[i] !== 32'hAAAA_0001) begin
                failures++; $display("FAIL overlap_data[%0d] got=%h want=aaaa0001", i, mem[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_zero_count();
        test_range_error();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_mm_block_copier.md
AVALON_MM_BLOCK_COPIER -- requirements
Module: avalon_mm_block_copier

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the master port.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 5120, number of addressable words in the target memory.
REQ-004 SHALL have parameter READ_LATENCY, default 1, fixed cycles from read acceptance to valid readdata (range 1-4).
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port start, input, 1: command strobe, sampled only in IDLE.
REQ-009 SHALL have port src_addr, input, ADDR_W: first source word address.
REQ-010 SHALL have port dst_addr, input, ADDR_W: first destination word address.
REQ-011 SHALL have port word_count, input, ADDR_W+1: words to copy.
REQ-012 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port error, output, 1: one-cycle pulse on a rejected command.
REQ-015 SHALL have port address, output, ADDR_W: Avalon-MM master word address.
REQ-016 SHALL have port chipselect, output, 1: high whenever read or write is high.
REQ-017 SHALL have ports read and write, output, 1 each: Avalon-MM commands, never both high together.
REQ-018 SHALL have port byteenable, output, DATA_W/8: all-ones during writes.
REQ-019 SHALL have port writedata, output, DATA_W: write data.
REQ-020 SHALL have port readdata, input, DATA_W: read data.
REQ-021 SHALL have port waitrequest, input, 1: command stall.

Function
REQ-022 SHALL implement FSM states IDLE, CHECK, RD, RD_WAIT, WR, DONE.
REQ-023 In IDLE with start=1, SHALL latch src_addr, dst_addr and word_count, then go to CHECK.
REQ-024 In CHECK, SHALL reject the command if src_addr+word_count>DEPTH or dst_addr+word_count>DEPTH (full-width compare, no wrap): error pulses and the FSM returns to IDLE with no bus traffic.
REQ-025 In CHECK, word_count=0 SHALL go to DONE with no bus traffic and no error.
REQ-026 In RD, SHALL drive read=1 with address=src+i, held until a cycle with waitrequest=0 (acceptance).
REQ-027 After read acceptance, SHALL capture readdata exactly READ_LATENCY cycles later (RD_WAIT), then enter WR.
REQ-028 In WR, SHALL drive write=1 with address=dst+i and writedata=captured word, held stable until waitrequest=0.
REQ-029 After write acceptance, SHALL increment i: if i<word_count go to RD next cycle, else go to DONE.
REQ-030 In DONE, SHALL pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-031 With waitrequest=0 and READ_LATENCY=1, throughput SHALL be exactly 3 cycles per word (RD, RD_WAIT, WR).
REQ-032 start while not IDLE SHALL be ignored, and input changes after latch SHALL have no effect.
REQ-033 Overlapping src/dst ranges SHALL copy in ascending order without hazard checking.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, error=0, read=0, write=0, chipselect=0, address=0, writedata=0, byteenable=0.
REQ-035 Reset mid-transfer SHALL abort immediately; no done pulse SHALL follow, and read/write SHALL be low the cycle after reset is sampled.

Structure
REQ-036 Package avalon_copier_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W/DEPTH constants.
REQ-037 Sub-module avalon_rd_latency_tracker (READ_LATENCY-deep valid shift register) SHALL generate the readdata capture strobe.

Verification
REQ-038 src=0, dst=100, count=4, waitrequest=0, memory model latency 1 -> words 0..3 appear at 100..103; busy high for 12 cycles; one done pulse.
REQ-039 count=0 -> done pulses 2 cycles after start; read/write never assert; error=0.
REQ-040 src=5118, count=3 -> error pulses once; no read/write; busy returns low.
REQ-041 waitrequest held high 3 cycles on each read and write, count=2 -> address/read/write/writedata stable during stalls; copied data is correct; busy lasts 18 cycles.
REQ-042 reset_n low for 1 cycle during the WR of word 2 of 5 -> outputs at reset values next cycle; no done; a fresh start completes normally.
REQ-043 start pulsed during busy with different arguments -> ignored; the original copy completes unchanged.
